// File: rtl/ram_bus_master_pkg.sv
// Shared defines for the RAM bus master: size/state encodings, store lane masks
// and small decode helpers used by the master and its load aligner.
package ram_bus_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam logic [3:0] WE_NONE    = 4'b0000;
  localparam logic [3:0] WE_BYTE0   = 4'b0001;
  localparam logic [3:0] WE_HALF_LO = 4'b0011;
  localparam logic [3:0] WE_HALF_HI = 4'b1100;
  localparam logic [3:0] WE_WORD    = 4'b1111;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    logic [3:0] m;
    m = WE_NONE;
    case (size)
      SZ_BYTE: m = WE_BYTE0 << off;
      SZ_HALF: m = off[1] ? WE_HALF_HI : WE_HALF_LO;
      SZ_WORD: m = WE_WORD;
      default: m = WE_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ram_bus_load_align.sv
// Load lane extraction: picks the byte/half addressed by offset from the
// captured bus word and zero- or sign-extends it to the full data width.
module ram_bus_load_align
  import ram_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  size_e                 size_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = rdata_i[{offset_i, 3'b000} +: 8];
    half_w = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = '0;
    case (size_i)
      SZ_BYTE: data_o = {{(DATA_WIDTH-8){signed_i & byte_w[7]}}, byte_w};
      SZ_HALF: data_o = {{(DATA_WIDTH-16){signed_i & half_w[15]}}, half_w};
      SZ_WORD: data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/ram_bus_master.sv
// Single-outstanding load/store master toward a word-wide slave RAM with
// lane steering, misalignment trapping and a WAIT-state timeout.
//
// state    | meaning
// ST_IDLE  | ready for a core request
// ST_ISSUE | one-cycle strobe to the slave
// ST_WAIT  | waiting for ack/err, timeout down-counter running
// ST_RESP  | one-cycle response to the core
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_misaligned_o,
  output logic                  stb_o,
  output logic [3:0]            we_o,
  output logic [DATA_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  size_e                 size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  we_q, we_d;
  logic [3:0]            we_mask_q, we_mask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;
  logic [7:0]            tmo_q, tmo_d;

  logic [31:0]           lane_wdata;
  logic [DATA_WIDTH-1:0] load_data;
  size_e                 req_size;

  assign req_size = size_e'(req_size_i);

  ram_bus_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata_i  (rdata_q),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      we_mask_q <= WE_NONE;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      we_q      <= we_d;
      we_mask_q <= we_mask_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    we_d       = we_q;
    we_mask_d  = we_mask_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mis_d      = mis_q;
    tmo_d      = tmo_q;
    lane_wdata = req_wdata_i[31:0];

    case (req_size)
      SZ_BYTE: lane_wdata = {4{req_wdata_i[7:0]}};
      SZ_HALF: lane_wdata = {2{req_wdata_i[15:0]}};
      default: lane_wdata = req_wdata_i[31:0];
    endcase

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          size_d   = req_size;
          signed_d = req_signed_i;
          we_d     = req_we_i;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (is_misaligned(req_size, req_addr_i[1:0])) begin
            mis_d     = 1'b1;
            we_mask_d = WE_NONE;
            wdata_d   = '0;
            state_d   = ST_RESP;
          end else begin
            mis_d     = 1'b0;
            we_mask_d = req_we_i ? lane_mask(req_size, req_addr_i[1:0]) : WE_NONE;
            wdata_d   = req_we_i ? DATA_WIDTH'(lane_wdata) : '0;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmo_d   = TMO_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // err wins over a simultaneous ack
        if (err_i) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (ack_i) begin
          rdata_d = rdata_i;
          state_d = ST_RESP;
        end else if (tmo_q == 8'd0) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      ST_RESP: begin
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o      = (state_q == ST_IDLE);
  assign stb_o            = (state_q == ST_ISSUE);
  assign we_o             = (state_q == ST_ISSUE) ? we_mask_q : WE_NONE;
  assign addr_o           = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign wdata_o          = wdata_q;
  assign rsp_valid_o      = (state_q == ST_RESP);
  assign rsp_err_o        = (state_q == ST_RESP) & err_q;
  assign rsp_misaligned_o = (state_q == ST_RESP) & mis_q;
  assign rsp_rdata_o      = ((state_q == ST_RESP) && !we_q && !err_q && !mis_q) ? load_data : '0;

endmodule
